// File: rtl/i2s_stream_buffer_if.sv
// i2s_stream_buffer_if: refill bus and audio-writer handshake of the stream buffer.
//   Refill side : request_data/request_size (out of buffer), request_finished,
//                 memory_data_strobe, memory_data (into buffer).
//   Audio side  : audio_data_request (into buffer), audio_data_ack,
//                 audio_data, audio_channel (out of buffer).
// modport slave is the buffer itself; modport master is the surrounding system.
interface i2s_stream_buffer_if #(
    parameter int unsigned SAMPLE_WIDTH = 24,
    parameter int unsigned CHANNEL_BITS = 1,
    parameter int unsigned ADDR_WIDTH   = 4
);
    logic                    request_data;
    logic [ADDR_WIDTH:0]     request_size;
    logic                    request_finished;
    logic                    memory_data_strobe;
    logic [31:0]             memory_data;
    logic                    audio_data_request;
    logic                    audio_data_ack;
    logic [SAMPLE_WIDTH-1:0] audio_data;
    logic [CHANNEL_BITS-1:0] audio_channel;

    modport slave (
        output request_data,
        output request_size,
        input  request_finished,
        input  memory_data_strobe,
        input  memory_data,
        input  audio_data_request,
        output audio_data_ack,
        output audio_data,
        output audio_channel
    );

    modport master (
        input  request_data,
        input  request_size,
        output request_finished,
        output memory_data_strobe,
        output memory_data,
        output audio_data_request,
        input  audio_data_ack,
        input  audio_data,
        input  audio_channel
    );
endinterface

// File: rtl/i2s_stream_buffer.sv
// i2s_stream_buffer: single-clock sample FIFO between a memory refill engine and
// an audio serializer. A fill FSM requests refills when occupancy falls to
// LOW_WATER; a read FSM serves the writer's level handshake, substituting a
// silent sample on the expected channel when the FIFO is empty.
// Ports:
//   clk, rst (async, active low)
//   enable      : run; low flushes the FIFO and idles both FSMs
//   mute        : zero delivered samples, still consume the FIFO
//   flag_clear  : clear sticky underrun/overflow
//   underrun, overflow : sticky flags
//   fifo_count  : occupancy 0..DEPTH
//   bus         : refill and audio handshake signals (slave modport)
module i2s_stream_buffer #(
    parameter int unsigned SAMPLE_WIDTH = 24,
    parameter int unsigned CHANNEL_BITS = 1,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned LOW_WATER    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                mute,
    input  logic                flag_clear,
    output logic                underrun,
    output logic                overflow,
    output logic [ADDR_WIDTH:0] fifo_count,
    i2s_stream_buffer_if.slave  bus
);
    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam int unsigned WORD_W = SAMPLE_WIDTH + CHANNEL_BITS;

    typedef enum logic {
        F_IDLE,
        F_FILL
    } fill_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_ACK
    } read_state_e;

    // FIFO storage and pointers
    logic [WORD_W-1:0]     mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    // Fill FSM
    fill_state_e           fill_state_q, fill_state_d;
    logic                  req_data_q, req_data_d;
    logic [CNT_W-1:0]      req_size_q, req_size_d;

    // Read FSM
    read_state_e           read_state_q, read_state_d;
    logic                  ack_q, ack_d;
    logic [SAMPLE_WIDTH-1:0] data_q, data_d;
    logic [CHANNEL_BITS-1:0] chan_q, chan_d;
    logic [CHANNEL_BITS-1:0] exp_chan_q, exp_chan_d;
    logic [WORD_W-1:0]     fetch_word_q, fetch_word_d;
    logic                  fetch_hit_q, fetch_hit_d;

    // Sticky flags
    logic                  underrun_q, underrun_d;
    logic                  overflow_q, overflow_d;

    logic                  full_c, empty_c;
    logic                  start_c, rd_en_c, wr_en_c, ovf_set_c, urun_set_c;
    logic [WORD_W-1:0]     in_word_c;
    logic                  unused_mem_bits_c;

    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == '0);

    // Only the sample field and the top channel field of a memory word matter.
    assign in_word_c = {bus.memory_data[31 -: CHANNEL_BITS], bus.memory_data[SAMPLE_WIDTH-1:0]};
    assign unused_mem_bits_c = ^bus.memory_data;

    // A handshake starts only from an idle read FSM with ack already low.
    assign start_c = (read_state_q == R_IDLE) && enable && bus.audio_data_request && !ack_q;
    assign rd_en_c = start_c && !empty_c;

    // A full FIFO still accepts a word when a read frees a slot in the same cycle.
    assign wr_en_c   = enable && bus.memory_data_strobe && (!full_c || rd_en_c);
    assign ovf_set_c = enable && bus.memory_data_strobe && full_c && !rd_en_c;

    // FIFO pointer and occupancy update; disable flushes.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (!enable) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en_c) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (rd_en_c) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            case ({wr_en_c, rd_en_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Fill FSM: one-cycle request pulse, then wait for the refill to finish.
    always_comb begin
        fill_state_d = fill_state_q;
        req_data_d   = 1'b0;
        req_size_d   = req_size_q;
        if (!enable) begin
            fill_state_d = F_IDLE;
        end else begin
            case (fill_state_q)
                F_IDLE: begin
                    if (count_q <= CNT_W'(LOW_WATER)) begin
                        req_data_d   = 1'b1;
                        req_size_d   = CNT_W'(DEPTH) - count_q;
                        fill_state_d = F_FILL;
                    end
                end
                F_FILL: begin
                    if (bus.request_finished) fill_state_d = F_IDLE;
                end
                default: fill_state_d = F_IDLE;
            endcase
        end
    end

    // Read FSM: IDLE pops the FIFO, FETCH presents the sample, ACK waits for release.
    always_comb begin
        read_state_d = read_state_q;
        ack_d        = ack_q;
        data_d       = data_q;
        chan_d       = chan_q;
        exp_chan_d   = exp_chan_q;
        fetch_word_d = fetch_word_q;
        fetch_hit_d  = fetch_hit_q;
        urun_set_c   = 1'b0;
        if (!enable) begin
            read_state_d = R_IDLE;
            ack_d        = 1'b0;
        end else begin
            case (read_state_q)
                R_IDLE: begin
                    if (start_c) begin
                        read_state_d = R_FETCH;
                        fetch_hit_d  = !empty_c;
                        if (!empty_c) fetch_word_d = mem_q[rd_ptr_q];
                    end
                end
                R_FETCH: begin
                    read_state_d = R_ACK;
                    ack_d        = 1'b1;
                    if (fetch_hit_q) begin
                        chan_d = fetch_word_q[WORD_W-1 -: CHANNEL_BITS];
                        data_d = mute ? '0 : fetch_word_q[SAMPLE_WIDTH-1:0];
                    end else begin
                        // Underrun: silence on the channel the writer expects next.
                        chan_d     = exp_chan_q;
                        data_d     = '0;
                        urun_set_c = 1'b1;
                    end
                    exp_chan_d = chan_d + CHANNEL_BITS'(1);
                end
                R_ACK: begin
                    if (!bus.audio_data_request) begin
                        read_state_d = R_IDLE;
                        ack_d        = 1'b0;
                    end
                end
                default: read_state_d = R_IDLE;
            endcase
        end
    end

    // Sticky flags; a set event in the same cycle wins over a clear.
    always_comb begin
        underrun_d = underrun_q;
        overflow_d = overflow_q;
        if (flag_clear) begin
            underrun_d = 1'b0;
            overflow_d = 1'b0;
        end
        if (urun_set_c) underrun_d = 1'b1;
        if (ovf_set_c)  overflow_d = 1'b1;
    end

    // FIFO storage, no reset needed: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (wr_en_c) mem_q[wr_ptr_q] <= in_word_c;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            fill_state_q <= F_IDLE;
            req_data_q   <= 1'b0;
            req_size_q   <= '0;
            read_state_q <= R_IDLE;
            ack_q        <= 1'b0;
            data_q       <= '0;
            chan_q       <= '0;
            exp_chan_q   <= '0;
            fetch_word_q <= '0;
            fetch_hit_q  <= 1'b0;
            underrun_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fill_state_q <= fill_state_d;
            req_data_q   <= req_data_d;
            req_size_q   <= req_size_d;
            read_state_q <= read_state_d;
            ack_q        <= ack_d;
            data_q       <= data_d;
            chan_q       <= chan_d;
            exp_chan_q   <= exp_chan_d;
            fetch_word_q <= fetch_word_d;
            fetch_hit_q  <= fetch_hit_d;
            underrun_q   <= underrun_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.request_data   = req_data_q;
    assign bus.request_size   = req_size_q;
    assign bus.audio_data_ack = ack_q;
    assign bus.audio_data     = data_q;
    assign bus.audio_channel  = chan_q;
    assign underrun           = underrun_q;
    assign overflow           = overflow_q;
    assign fifo_count         = count_q;
endmodule

// File: tb/tb_i2s_stream_buffer.sv
// Directed bench for i2s_stream_buffer at default parameters (DEPTH 16, LOW_WATER 4).
module tb_i2s_stream_buffer;
    localparam int unsigned SW = 24;
    localparam int unsigned CB = 1;
    localparam int unsigned AW = 4;
    localparam int unsigned LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          mute;
    logic          flag_clear;
    logic          underrun;
    logic          overflow;
    logic [AW:0]   fifo_count;

    int            total = 0;
    int            bad = 0;
    int            req_pulses = 0;
    logic [AW:0]   last_req_size = '0;

    logic [SW-1:0] d;
    logic [CB-1:0] ch;
    int            lat;
    logic          ack_hold;
    logic          ack_drop;

    i2s_stream_buffer_if #(.SAMPLE_WIDTH(SW), .CHANNEL_BITS(CB), .ADDR_WIDTH(AW)) bus ();

    i2s_stream_buffer #(
        .SAMPLE_WIDTH(SW),
        .CHANNEL_BITS(CB),
        .ADDR_WIDTH(AW),
        .LOW_WATER(LW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .mute(mute),
        .flag_clear(flag_clear),
        .underrun(underrun),
        .overflow(overflow),
        .fifo_count(fifo_count),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Count refill request pulses and remember the size of the latest one.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.request_data === 1'b1) begin
            req_pulses++;
            last_req_size = bus.request_size;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int i);
        if (i == 0) return 32'h80000123;
        if (i == 1) return 32'h00000456;
        return {i[0], 31'(i)};
    endfunction

    task automatic strobe(input logic [31:0] w);
        bus.memory_data        = w;
        bus.memory_data_strobe = 1'b1;
        tick();
        bus.memory_data_strobe = 1'b0;
    endtask

    // One writer handshake; ack wait is bounded so a stuck DUT shows up as lat != 2.
    task automatic hs(input int hold, output logic [SW-1:0] dq, output logic [CB-1:0] cq,
                      output int lq, output logic held, output logic dropped);
        bus.audio_data_request = 1'b1;
        lq = 0;
        while (bus.audio_data_ack !== 1'b1 && lq < 10) begin
            tick();
            lq++;
        end
        dq = bus.audio_data;
        cq = bus.audio_channel;
        repeat (hold) tick();
        held = bus.audio_data_ack;
        bus.audio_data_request = 1'b0;
        tick();
        dropped = bus.audio_data_ack;
    endtask

    initial begin
        rst = 1'b0;
        enable = 1'b0;
        mute = 1'b0;
        flag_clear = 1'b0;
        bus.request_finished = 1'b0;
        bus.memory_data_strobe = 1'b0;
        bus.memory_data = '0;
        bus.audio_data_request = 1'b0;
        repeat (3) tick();

        chk("rst_request_data", 32'(bus.request_data), 0);
        chk("rst_request_size", 32'(bus.request_size), 0);
        chk("rst_ack", 32'(bus.audio_data_ack), 0);
        chk("rst_audio_data", 32'(bus.audio_data), 0);
        chk("rst_audio_channel", 32'(bus.audio_channel), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_fifo_count", 32'(fifo_count), 0);

        // Empty FIFO: one request for the full depth.
        rst = 1'b1;
        enable = 1'b1;
        tick();
        chk("first_req_pulse", 32'(bus.request_data), 1);
        chk("first_req_size", 32'(bus.request_size), 16);
        tick();
        chk("first_req_one_cycle", 32'(bus.request_data), 0);

        for (int i = 0; i < 16; i++) strobe(word_of(i));
        bus.request_finished = 1'b1;
        tick();
        bus.request_finished = 1'b0;
        repeat (4) tick();
        chk("fill_count", 32'(fifo_count), 16);
        chk("fill_no_second_req", 32'(req_pulses), 1);

        // 17th word into a full FIFO is dropped.
        strobe(32'hDEADBEEF);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(fifo_count), 16);

        // First read: oldest word, request held high through ACK.
        hs(3, d, ch, lat, ack_hold, ack_drop);
        chk("rd0_data", 32'(d), 32'h123);
        chk("rd0_chan", 32'(ch), 1);
        chk("rd0_latency", 32'(lat), 2);
        chk("rd0_ack_held", 32'(ack_hold), 1);
        chk("rd0_ack_drop", 32'(ack_drop), 0);
        chk("rd0_single_pop", 32'(fifo_count), 15);

        hs(0, d, ch, lat, ack_hold, ack_drop);
        chk("rd1_data", 32'(d), 32'h456);
        chk("rd1_chan", 32'(ch), 0);
        chk("rd1_latency", 32'(lat), 2);
        chk("rd1_count", 32'(fifo_count), 14);

        flag_clear = 1'b1;
        tick();
        flag_clear = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);

        // Muted read still pops and keeps the channel.
        mute = 1'b1;
        hs(0, d, ch, lat, ack_hold, ack_drop);
        mute = 1'b0;
        chk("mute_data", 32'(d), 0);
        chk("mute_chan", 32'(ch), 0);
        chk("mute_count", 32'(fifo_count), 13);

        // Drain the rest; the refill fires when occupancy reaches 4.
        for (int i = 3; i < 16; i++) begin
            hs(0, d, ch, lat, ack_hold, ack_drop);
            chk($sformatf("drain%0d_data", i), 32'(d), 32'(i));
            chk($sformatf("drain%0d_chan", i), 32'(ch), 32'(i % 2));
        end
        chk("refill_pulses", 32'(req_pulses), 2);
        chk("refill_size", 32'(last_req_size), 12);
        chk("drained_count", 32'(fifo_count), 0);

        // Underrun after channel 1 was delivered.
        hs(0, d, ch, lat, ack_hold, ack_drop);
        chk("urun_data", 32'(d), 0);
        chk("urun_chan", 32'(ch), 0);
        chk("urun_latency", 32'(lat), 2);
        chk("urun_flag", 32'(underrun), 1);
        flag_clear = 1'b1;
        tick();
        flag_clear = 1'b0;
        chk("urun_cleared", 32'(underrun), 0);

        // Reset in the middle of a refill with 5 words stored.
        for (int k = 0; k < 6; k++) strobe(32'h80000AB0 + 32'(k));
        hs(0, d, ch, lat, ack_hold, ack_drop);
        chk("pre_rst_data", 32'(d), 32'hAB0);
        chk("pre_rst_count", 32'(fifo_count), 5);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_count", 32'(fifo_count), 0);
        chk("mid_rst_size", 32'(bus.request_size), 0);
        chk("mid_rst_data", 32'(bus.audio_data), 0);
        chk("mid_rst_chan", 32'(bus.audio_channel), 0);
        repeat (2) tick();
        chk("rst_no_pulse", 32'(req_pulses), 2);
        rst = 1'b1;
        tick();
        chk("post_rst_req", 32'(bus.request_data), 1);
        chk("post_rst_size", 32'(bus.request_size), 16);

        // Disable flushes, holds audio_data and ignores strobes.
        for (int k = 1; k < 4; k++) strobe(32'h80000C00 + 32'(k));
        hs(0, d, ch, lat, ack_hold, ack_drop);
        chk("en_rd_data", 32'(d), 32'hC01);
        chk("en_rd_count", 32'(fifo_count), 2);
        enable = 1'b0;
        tick();
        chk("dis_flush", 32'(fifo_count), 0);
        chk("dis_data_held", 32'(bus.audio_data), 32'hC01);
        strobe(32'h00000777);
        tick();
        chk("dis_strobe_ignored", 32'(fifo_count), 0);
        chk("dis_no_request", 32'(req_pulses), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2s_stream_buffer.md
I2S_STREAM_BUFFER -- requirements
Module: i2s_stream_buffer

Interface
REQ-001 The block SHALL have parameter SAMPLE_WIDTH, default 24, meaning audio sample width in bits (8..24).
REQ-002 The block SHALL have parameter CHANNEL_BITS, default 1, meaning the channel count is 2^CHANNEL_BITS (1..3).
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 4, meaning FIFO depth DEPTH = 2^ADDR_WIDTH words.
REQ-004 The block SHALL have parameter LOW_WATER, default 4, meaning the refill threshold in words (< DEPTH).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port enable, input, 1 bit: the block runs when high.
REQ-008 The block SHALL have port mute, input, 1 bit: zeroes audio_data while still consuming the FIFO.
REQ-009 The block SHALL have port request_data, output, 1 bit: one-cycle memory refill request pulse.
REQ-010 The block SHALL have port request_size, output, ADDR_WIDTH+1 bits: words requested, held stable from the pulse until request_finished.
REQ-011 The block SHALL have ports request_finished (input, 1), memory_data_strobe (input, 1) and memory_data (input, 32): refill completion, and write strobe plus data.
REQ-012 The block SHALL have ports audio_data_request (input, 1) and audio_data_ack (output, 1): the writer-side level handshake.
REQ-013 The block SHALL have ports audio_data (output, SAMPLE_WIDTH) and audio_channel (output, CHANNEL_BITS): the sample and its channel index.
REQ-014 The block SHALL have ports underrun and overflow (outputs, 1 each, sticky flags), flag_clear (input, 1) and fifo_count (output, ADDR_WIDTH+1).

Function
REQ-015 Memory word format: sample = memory_data[SAMPLE_WIDTH-1:0]; channel = memory_data[31 -: CHANNEL_BITS]; other bits are ignored.
REQ-016 The FIFO is synchronous and single-clock; fifo_count is the occupancy 0..DEPTH.
REQ-017 A simultaneous write and read in one cycle leaves fifo_count unchanged.
REQ-018 Pointers wrap modulo DEPTH.
REQ-019 The fill FSM has two states, IDLE and FILL.
REQ-020 In IDLE with enable=1 and fifo_count <= LOW_WATER, the fill FSM pulses request_data for exactly 1 cycle, latches request_size = DEPTH - fifo_count, and enters FILL.
REQ-021 In FILL, request_data stays 0 and every memory_data_strobe writes one word.
REQ-022 In FILL, request_finished returns the fill FSM to IDLE the next cycle; a new request requires a re-evaluation in IDLE, so the minimum gap between requests is 1 cycle.
REQ-023 A strobe while fifo_count == DEPTH (and no same-cycle read) drops the word and sets overflow; the FIFO is not corrupted.
REQ-024 Strobes while in IDLE are still written if space exists.
REQ-025 The read FSM has three states: IDLE, FETCH and ACK.
REQ-026 In IDLE, with enable=1, audio_data_request=1 and audio_data_ack=0, the read FSM issues a FIFO read if fifo_count > 0 and enters FETCH.
REQ-027 In FETCH, the read FSM registers the sample and channel, asserts audio_data_ack, and enters ACK; ack rises 2 cycles after the request is first sampled high.
REQ-028 In ACK, audio_data_ack holds until audio_data_request is sampled low, then deasserts the next cycle and the FSM returns to IDLE.
REQ-029 A request that stays high during ACK does not start a new fetch.
REQ-030 Underrun: a request in IDLE with fifo_count == 0 proceeds through FETCH with no FIFO read.
REQ-031 On underrun, audio_data is 0, audio_channel is the expected channel, and underrun is set.
REQ-032 Expected channel = last delivered audio_channel + 1, modulo 2^CHANNEL_BITS.
REQ-033 mute=1 forces audio_data to 0; audio_channel and FIFO consumption are unaffected.
REQ-034 flag_clear=1 clears underrun and overflow the next cycle; a same-cycle set event wins over the clear.
REQ-035 enable=0 flushes the FIFO (fifo_count -> 0), returns both FSMs to IDLE, deasserts audio_data_ack and ignores strobes; audio_data is held; flags are retained.

Reset
REQ-036 rst=0 asynchronously forces request_data=0, request_size=0, audio_data_ack=0, audio_data=0, audio_channel=0, underrun=0, overflow=0, fifo_count=0, both FSMs to IDLE and expected channel to 0.
REQ-037 Reset asserted mid-refill or mid-handshake SHALL abandon the operation with no request_data pulse on release.
REQ-038 The first refill request occurs no earlier than the first clk edge after rst rises with enable=1.

Verification
REQ-039 Empty FIFO, enable=1, DEPTH=16, LOW_WATER=4 -> one request_data pulse with request_size=16; 16 strobes then request_finished -> fifo_count=16 and no further request.
REQ-040 Words 0x80000123 and 0x00000456 loaded, two handshakes -> audio_data=0x000456 then 0x000123 is wrong order; required order is 0x000123/channel 1, then 0x000456/channel 0; ack rises 2 cycles after each request.
REQ-041 Draining a full FIFO to 4 words -> request_data pulses with request_size=12.
REQ-042 Request with an empty FIFO after delivering channel 1 -> ack with audio_data=0 and audio_channel=0, underrun=1; flag_clear -> underrun=0.
REQ-043 17th strobe into a full 16-deep FIFO -> overflow=1, fifo_count stays 16, and the next read returns the first word.
REQ-044 rst pulsed low during FILL with 5 words stored -> all outputs at reset values immediately; after release, fifo_count=0 and the first request has request_size=16.
